// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and constants for the SPI register bank.
//   spi_state_e  frame FSM states (IDLE, CMD, ADDR, DATA)
//   RW_WRITE / RW_READ  values of the frame's leading R/W bit
//   SYNC_STAGES  depth of the metastability synchroniser on each SPI pin
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        ADDR,
        DATA
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: SPI pin bundle between the controller and the register bank.
//   SCLK  SPI clock (mode 0), async to the system clock
//   COPI  controller-out data
//   nCS   chip select, active low
//   CIPO  peripheral-out data
// Modports: master (controller / testbench side), slave (peripheral side).
interface spi_reg_bank_if;

    logic SCLK;
    logic COPI;
    logic nCS;
    logic CIPO;

    modport master (output SCLK, output COPI, output nCS, input CIPO);
    modport slave  (input SCLK, input COPI, input nCS, output CIPO);

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser plus one extra stage for edge detection.
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous input
//   level     synchronised level
//   rise/fall one-cycle pulses on synchronised transitions
// IDLE_LVL is the reset value of every stage, so reset never fabricates an edge
// while the pin rests at its idle level.
module spi_sync_edge
    import spi_reg_pkg::*;
#(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {(SYNC_STAGES + 1){IDLE_LVL}};
        end else begin
            sr <= {sr[SYNC_STAGES-1:0], din};
        end
    end

    assign level = sr[SYNC_STAGES-1];
    assign rise  =  sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
    assign fall  = ~sr[SYNC_STAGES-1] &  sr[SYNC_STAGES];

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral writing (optionally reading) NUM_REGS x DATA_W registers.
// Frame, MSB first: R/W bit (1=write), ADDR_W address bits, then any number of DATA_W words
// with address auto-increment (NUM_REGS-1 wraps to 0).
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   spi        SPI pins (slave modport): SCLK, COPI, nCS in; CIPO out
//   regs_flat  register i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse per committed word
//   wr_addr    address of the last commit
// Optional feature: define SPI_REG_READ_EN to build the read path (CIPO shift register);
// otherwise CIPO is tied low.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_reg_bank_if.slave                spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);

    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam logic [2:0]  FLUSH = 3'(SYNC_STAGES + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic unused_sig;

    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi.SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.IDLE_LVL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi.nCS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(spi.COPI),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    assign unused_sig = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_sr;
    logic                   rw_q;
    logic                   commit_pend;
    logic [2:0]             flush_cnt;
    logic                   armed;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];

    logic shift_cmd, shift_addr, shift_data, addr_last, word_last;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(NUM_REGS - 1)) return '0;
        return a + 1'b1;
    endfunction

    // After reset the nCS chain starts at the idle level; if the pin is already low the
    // chain produces a fall that is not a real frame start. Accept falls only once nCS
    // has been seen high after the chain has flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else if (flush_cnt != FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else if (cs_lvl) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // nCS rise has priority over a coincident SCLK rise: that bit is dropped.
    always_comb begin
        state_d    = state_q;
        shift_cmd  = 1'b0;
        shift_addr = 1'b0;
        shift_data = 1'b0;
        addr_last  = 1'b0;
        word_last  = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall && armed) state_d = CMD;
                CMD: if (sclk_rise) begin
                    shift_cmd = 1'b1;
                    state_d   = ADDR;
                end
                ADDR: if (sclk_rise) begin
                    shift_addr = 1'b1;
                    if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                        addr_last = 1'b1;
                        state_d   = DATA;
                    end
                end
                DATA: if (sclk_rise) begin
                    shift_data = 1'b1;
                    word_last  = (bit_cnt == CNT_W'(DATA_W - 1));
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completed word is committed one clk after the SCLK rise that sampled its last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            addr_q      <= '0;
            data_sr     <= '0;
            rw_q        <= RW_READ;
            commit_pend <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe   <= 1'b0;
            commit_pend <= 1'b0;
            if (state_q == IDLE || cs_rise) bit_cnt <= '0;
            if (shift_cmd) begin
                rw_q    <= copi_lvl;
                bit_cnt <= '0;
            end
            if (shift_addr) begin
                addr_q  <= ADDR_W'({addr_q, copi_lvl});
                bit_cnt <= addr_last ? '0 : bit_cnt + 1'b1;
            end
            if (shift_data) begin
                data_sr     <= DATA_W'({data_sr, copi_lvl});
                bit_cnt     <= word_last ? '0 : bit_cnt + 1'b1;
                commit_pend <= word_last;
            end
            if (commit_pend) begin
                if (rw_q == RW_WRITE && 32'(addr_q) < NUM_REGS) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) regs_q[i] <= data_sr;
                    end
                    wr_strobe <= 1'b1;
                    wr_addr   <= addr_q;
                end
                addr_q <= addr_inc(addr_q);
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

`ifdef SPI_REG_READ_EN
    logic [DATA_W-1:0] rd_sr;

    function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) v = regs_q[i];
        end
        return v;
    endfunction

    // bit_cnt==0 in DATA means the SCLK fall follows a load/reload: hold the fresh MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sr <= '0;
        end else if (addr_last && rw_q == RW_READ) begin
            rd_sr <= reg_at(ADDR_W'({addr_q, copi_lvl}));
        end else if (commit_pend) begin
            rd_sr <= reg_at(addr_inc(addr_q));
        end else if (sclk_fall && state_q == DATA && bit_cnt != '0) begin
            rd_sr <= rd_sr << 1;
        end
    end

    assign spi.CIPO = (state_q == DATA && rw_q == RW_READ) ? rd_sr[DATA_W-1] : 1'b0;
`else
    assign spi.CIPO = 1'b0;
`endif

endmodule
